// File: rtl/i2c_reg_pkg.sv
// rtl/i2c_reg_pkg.sv - shared state encoding, default address and register map for i2c_register_bank
package i2c_reg_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PTR   = 2'd1,
    S_WRITE = 2'd2,
    S_READ  = 2'd3
  } state_t;

  localparam logic [6:0] DEFAULT_I2C_ADDRESS = 7'h42;
  localparam int         DEFAULT_NUM_REGS    = 16;
  localparam int         DEFAULT_NUM_RW      = 8;

  // Register map as seen by firmware: control block first, status block after it
  localparam int REG_CTRL_BASE   = 0;
  localparam int REG_STATUS_BASE = DEFAULT_NUM_RW;
  localparam int REG_LAST        = DEFAULT_NUM_REGS - 1;

endpackage

// File: rtl/i2c_reg_file.sv
// rtl/i2c_reg_file.sv - control register storage with write port and ctrl/status read mux
module i2c_reg_file
  import i2c_reg_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int NUM_RW   = DEFAULT_NUM_RW,
  parameter int PTR_W    = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [PTR_W-1:0]               wr_addr,
  input  logic [7:0]                     wr_data,
  input  logic [PTR_W-1:0]               rd_addr,
  output logic [7:0]                     rd_data,
  input  logic [(NUM_REGS-NUM_RW)*8-1:0] status_in,
  output logic [NUM_RW*8-1:0]            ctrl_regs
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_regs <= '0;
    end else begin
      for (int i = 0; i < NUM_RW; i++) begin
        if (wr_en && wr_addr == PTR_W'(i)) ctrl_regs[i*8 +: 8] <= wr_data;
      end
    end
  end

  // Indices past the control block read the live status inputs
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (rd_addr == PTR_W'(i)) rd_data = ctrl_regs[i*8 +: 8];
    end
    for (int j = 0; j < NUM_REGS - NUM_RW; j++) begin
      if (rd_addr == PTR_W'(j + NUM_RW)) rd_data = status_in[j*8 +: 8];
    end
  end

endmodule

// File: rtl/i2c_register_bank.sv
// rtl/i2c_register_bank.sv - pointer-addressed I2C register bank; I2C_REG_AUTOINC_EN enables pointer auto-increment
module i2c_register_bank
  import i2c_reg_pkg::*;
#(
  parameter logic [6:0] I2C_ADDRESS = DEFAULT_I2C_ADDRESS,
  parameter int         NUM_REGS    = DEFAULT_NUM_REGS,
  parameter int         NUM_RW      = DEFAULT_NUM_RW,
  parameter int         PTR_W       = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [7:0]                     i2c_addr_rw,
  input  logic                           i2c_addr_rw_valid_stb,
  input  logic [7:0]                     i2c_data_rx,
  input  logic                           i2c_data_rx_valid_stb,
  output logic [7:0]                     i2c_data_tx,
  input  logic                           i2c_data_tx_done_stb,
  input  logic                           i2c_error_stb,
  output logic                           stall,
  output logic [NUM_RW*8-1:0]            ctrl_regs,
  input  logic [(NUM_REGS-NUM_RW)*8-1:0] status_in,
  output logic                           reg_wr_stb,
  output logic [PTR_W-1:0]               reg_wr_addr
);

  state_t           state, state_n;
  logic [PTR_W-1:0] ptr, ptr_n;
  logic [PTR_W-1:0] ptr_from_rx;
  logic             addr_match;
  logic             wr_en;
  logic             accepted;
  logic [1:0]       stall_cnt;
  logic [7:0]       rd_data;

  assign addr_match  = (i2c_addr_rw[7:1] == I2C_ADDRESS);
  assign ptr_from_rx = PTR_W'({24'd0, i2c_data_rx} % NUM_REGS);
  assign stall       = (stall_cnt != 2'd0);

`ifdef I2C_REG_AUTOINC_EN
  logic [PTR_W-1:0] ptr_inc;
  assign ptr_inc = (ptr == PTR_W'(NUM_REGS - 1)) ? '0 : ptr + PTR_W'(1);
`endif

  // Strobe priority: error > address > rx > tx_done
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    wr_en    = 1'b0;
    accepted = 1'b0;
    if (i2c_error_stb) begin
      state_n = S_IDLE;
    end else if (i2c_addr_rw_valid_stb) begin
      accepted = 1'b1;
      if (addr_match) state_n = i2c_addr_rw[0] ? S_READ : S_PTR;
      else            state_n = S_IDLE;
    end else if (i2c_data_rx_valid_stb) begin
      case (state)
        S_PTR: begin
          accepted = 1'b1;
          ptr_n    = ptr_from_rx;
          state_n  = S_WRITE;
        end
        S_WRITE: begin
          accepted = 1'b1;
          wr_en    = (ptr < PTR_W'(NUM_RW));
`ifdef I2C_REG_AUTOINC_EN
          ptr_n    = ptr_inc;
`endif
        end
        default: ;
      endcase
    end else if (i2c_data_tx_done_stb && state == S_READ) begin
      accepted = 1'b1;
`ifdef I2C_REG_AUTOINC_EN
      ptr_n    = ptr_inc;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ptr         <= '0;
      stall_cnt   <= 2'd0;
      i2c_data_tx <= 8'd0;
      reg_wr_stb  <= 1'b0;
      reg_wr_addr <= '0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      i2c_data_tx <= rd_data;
      reg_wr_stb  <= wr_en;
      if (wr_en) reg_wr_addr <= ptr;
      // Two stall cycles cover the ptr update and the tx byte reload behind it
      if (accepted)               stall_cnt <= 2'd2;
      else if (stall_cnt != 2'd0) stall_cnt <= stall_cnt - 2'd1;
    end
  end

  i2c_reg_file #(
    .NUM_REGS (NUM_REGS),
    .NUM_RW   (NUM_RW),
    .PTR_W    (PTR_W)
  ) u_reg_file (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (ptr),
    .wr_data   (i2c_data_rx),
    .rd_addr   (ptr),
    .rd_data   (rd_data),
    .status_in (status_in),
    .ctrl_regs (ctrl_regs)
  );

endmodule

// File: tb/tb_i2c_register_bank.sv
// tb/tb_i2c_register_bank.sv - scoreboard bench for i2c_register_bank; follows I2C_REG_AUTOINC_EN if defined
module tb_i2c_register_bank;

  localparam int NUM_REGS = 16;
  localparam int NUM_RW   = 8;
  localparam int PTR_W    = 4;

  logic                           clk = 1'b0;
  logic                           rst_n;
  logic [7:0]                     i2c_addr_rw;
  logic                           i2c_addr_rw_valid_stb;
  logic [7:0]                     i2c_data_rx;
  logic                           i2c_data_rx_valid_stb;
  logic [7:0]                     i2c_data_tx;
  logic                           i2c_data_tx_done_stb;
  logic                           i2c_error_stb;
  logic                           stall;
  logic [NUM_RW*8-1:0]            ctrl_regs;
  logic [(NUM_REGS-NUM_RW)*8-1:0] status_in;
  logic                           reg_wr_stb;
  logic [PTR_W-1:0]               reg_wr_addr;

  always #5 clk = ~clk;

  i2c_register_bank #(
    .I2C_ADDRESS (7'h42),
    .NUM_REGS    (NUM_REGS),
    .NUM_RW      (NUM_RW),
    .PTR_W       (PTR_W)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .i2c_addr_rw           (i2c_addr_rw),
    .i2c_addr_rw_valid_stb (i2c_addr_rw_valid_stb),
    .i2c_data_rx           (i2c_data_rx),
    .i2c_data_rx_valid_stb (i2c_data_rx_valid_stb),
    .i2c_data_tx           (i2c_data_tx),
    .i2c_data_tx_done_stb  (i2c_data_tx_done_stb),
    .i2c_error_stb         (i2c_error_stb),
    .stall                 (stall),
    .ctrl_regs             (ctrl_regs),
    .status_in             (status_in),
    .reg_wr_stb            (reg_wr_stb),
    .reg_wr_addr           (reg_wr_addr)
  );

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  int         checks = 0;
  int         errors = 0;
  wr_t        wr_q[$];
  logic [7:0] tx_q[$];
  wr_t        mon_e;
  logic [7:0] m_ctrl[NUM_RW];
  int         m_ptr;
  int         m_state; // 0 idle, 1 ptr, 2 write, 3 read

  function automatic logic [7:0] m_reg(input int p);
    if (p < NUM_RW) return m_ctrl[p];
    return status_in[(p-NUM_RW)*8 +: 8];
  endfunction

  function automatic logic [63:0] m_flat();
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < NUM_RW; i++) f[i*8 +: 8] = m_ctrl[i];
    return f;
  endfunction

  function automatic int m_adv(input int p);
`ifdef I2C_REG_AUTOINC_EN
    return (p == NUM_REGS-1) ? 0 : p + 1;
`else
    return p;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write strobes are popped from the scoreboard as the DUT reports them
  always @(negedge clk) begin
    if (rst_n === 1'b1 && reg_wr_stb === 1'b1) begin
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL wr_stb_unexpected observed_addr=%0d expected=none", reg_wr_addr);
      end else begin
        mon_e = wr_q.pop_front();
        checks++;
        assert ({reg_wr_addr, ctrl_regs[reg_wr_addr*8 +: 8]} === {mon_e.addr, mon_e.data}) else begin
          errors++;
          $error("FAIL wr_stb observed=%h/%h expected=%h/%h", reg_wr_addr,
                 ctrl_regs[reg_wr_addr*8 +: 8], mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic strobe(input logic e, input logic a, input logic r, input logic t,
                        input logic [7:0] ab, input logic [7:0] rb);
    logic acc;
    @(posedge clk); #1;
    i2c_error_stb         = e;
    i2c_addr_rw_valid_stb = a;
    i2c_addr_rw           = ab;
    i2c_data_rx_valid_stb = r;
    i2c_data_rx           = rb;
    i2c_data_tx_done_stb  = t;
    acc = 1'b0;
    if (e) begin
      m_state = 0;
    end else if (a) begin
      acc = 1'b1;
      if (ab[7:1] == 7'h42) m_state = ab[0] ? 3 : 1;
      else                  m_state = 0;
    end else if (r) begin
      if (m_state == 1) begin
        acc = 1'b1;
        m_ptr = int'(rb) % NUM_REGS;
        m_state = 2;
      end else if (m_state == 2) begin
        acc = 1'b1;
        if (m_ptr < NUM_RW) begin
          m_ctrl[m_ptr] = rb;
          wr_q.push_back({4'(m_ptr), rb});
        end
        m_ptr = m_adv(m_ptr);
      end
    end else if (t && m_state == 3) begin
      acc = 1'b1;
      m_ptr = m_adv(m_ptr);
    end
    tx_q.push_back(m_reg(m_ptr));
    @(posedge clk); #1;
    i2c_error_stb         = 1'b0;
    i2c_addr_rw_valid_stb = 1'b0;
    i2c_data_rx_valid_stb = 1'b0;
    i2c_data_tx_done_stb  = 1'b0;
    if (!e) chk("stall_cycle1", 64'(stall), 64'(acc));
    @(posedge clk); #1;
    if (!e) chk("stall_cycle2", 64'(stall), 64'(acc));
    @(posedge clk); #1;
    chk("stall_released", 64'(stall), 64'd0);
    chk("data_tx", 64'(i2c_data_tx), 64'(tx_q.pop_front()));
  endtask

  task automatic addr_b(input logic [7:0] b); strobe(1'b0, 1'b1, 1'b0, 1'b0, b, 8'h00); endtask
  task automatic rx_b(input logic [7:0] b);   strobe(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, b); endtask
  task automatic tx_done();                   strobe(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00); endtask

  initial begin
    rst_n                 = 1'b0;
    i2c_addr_rw           = 8'h00;
    i2c_addr_rw_valid_stb = 1'b0;
    i2c_data_rx           = 8'h00;
    i2c_data_rx_valid_stb = 1'b0;
    i2c_data_tx_done_stb  = 1'b0;
    i2c_error_stb         = 1'b0;
    for (int i = 0; i < NUM_REGS - NUM_RW; i++) status_in[i*8 +: 8] = 8'hA0 + 8'(i);
    for (int i = 0; i < NUM_RW; i++) m_ctrl[i] = 8'h00;
    m_ptr   = 0;
    m_state = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl_regs", ctrl_regs, 64'd0);
    chk("rst_data_tx", 64'(i2c_data_tx), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_wr_stb", 64'(reg_wr_stb), 64'd0);
    chk("rst_wr_addr", 64'(reg_wr_addr), 64'd0);
    rst_n = 1'b1;

    addr_b(8'h84); rx_b(8'h02); rx_b(8'hAA); rx_b(8'h55);
    chk("ctrl_after_first_write", ctrl_regs, m_flat());

    addr_b(8'h84); rx_b(8'h02);
    addr_b(8'h85); tx_done(); tx_done(); tx_done();
    chk("read_ptr_model", 64'(m_ptr), 64'(m_adv(m_adv(m_adv(2)))));

    addr_b(8'h84); rx_b(8'h0F); rx_b(8'h11); rx_b(8'h22);
    chk("ctrl_after_wrap_write", ctrl_regs, m_flat());

    addr_b(8'h86); rx_b(8'h77);
    chk("ctrl_after_foreign_addr", ctrl_regs, m_flat());

    addr_b(8'h84); rx_b(8'h03);
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    rx_b(8'h99);
    addr_b(8'h84); rx_b(8'h05); rx_b(8'h66);
    chk("ctrl_after_error", ctrl_regs, m_flat());

    addr_b(8'h84); rx_b(8'h01); rx_b(8'h10); rx_b(8'h20);
    addr_b(8'h84); rx_b(8'h01);
    addr_b(8'h85); tx_done(); tx_done();
    chk("ctrl_after_reg1_write", ctrl_regs, m_flat());

    addr_b(8'h84); rx_b(8'h13); rx_b(8'h3C);
    chk("ctrl_after_ptr_mod", ctrl_regs, m_flat());

    addr_b(8'h84); rx_b(8'h0A); addr_b(8'h85);
    status_in[2*8 +: 8] = 8'h5E;
    repeat (3) @(posedge clk);
    #1;
    chk("status_live", 64'(i2c_data_tx), 64'(m_reg(m_ptr)));

    // error and address in the same cycle: error wins, following rx is ignored
    addr_b(8'h84);
    strobe(1'b1, 1'b1, 1'b0, 1'b0, 8'h84, 8'h00);
    rx_b(8'h33); rx_b(8'h44);
    // address and rx together: address wins, rx byte is not taken as pointer
    strobe(1'b0, 1'b1, 1'b1, 1'b0, 8'h84, 8'h06);
    rx_b(8'h04); rx_b(8'h7E);
    chk("ctrl_after_priority", ctrl_regs, m_flat());

    repeat (2) @(posedge clk);
    chk("wr_queue_drained", 64'(wr_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
